sfx_arbiter: RTL and testbench

Sound-effect arbiter and sequencer that shares the single piezo `beep` output among four game-event requesters: key click, block landed, line cleared and game over. It sits between the game core, the keyboard controller and the board buzzer pin. It latches event pulses, grants the output by fixed priority with preemption, and plays each effect as a square tone of fixed pitch and duration, with a short silent gap between effects.

---
 rtl/sfx_pkg.sv | 47 ++++
 rtl/sfx_arbiter_if.sv | 20 ++
 rtl/sfx_tone_gen.sv | 57 +++++
 rtl/sfx_arbiter.sv | 130 +++++++++++++
 tb/tb_sfx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfx_pkg.sv
// Shared constants for the sound-effect arbiter: effect ids, tone/duration
// tables and the helpers that turn them into clock-cycle counts.
package sfx_pkg;

    localparam logic [1:0] SFX_CLICK = 2'd0;
    localparam logic [1:0] SFX_LAND  = 2'd1;
    localparam logic [1:0] SFX_LINE  = 2'd2;
    localparam logic [1:0] SFX_OVER  = 2'd3;

    localparam logic [1:0] GAME_IDLE = 2'b00;

    localparam int NUM_SFX = 4;
    localparam int SFX_FREQ_HZ [NUM_SFX] = '{1000, 500, 1500, 250};
    localparam int SFX_DUR_MS  [NUM_SFX] = '{20, 60, 150, 500};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } sfx_state_e;

    function automatic int half_period(int clk_hz, logic [1:0] id);
        return clk_hz / (2 * SFX_FREQ_HZ[id]);
    endfunction

    function automatic int dur_cycles(int clk_hz, logic [1:0] id);
        return SFX_DUR_MS[id] * (clk_hz / 1000);
    endfunction

    // Largest table entries at a given clock, used to size the counters.
    function automatic int max_half(int clk_hz);
        int m;
        m = 1;
        for (int i = 0; i < NUM_SFX; i++)
            if (half_period(clk_hz, 2'(i)) > m) m = half_period(clk_hz, 2'(i));
        return m;
    endfunction

    function automatic int max_dur(int clk_hz);
        int m;
        m = 1;
        for (int i = 0; i < NUM_SFX; i++)
            if (dur_cycles(clk_hz, 2'(i)) > m) m = dur_cycles(clk_hz, 2'(i));
        return m;
    endfunction

endpackage

// File: rtl/sfx_arbiter_if.sv
// Event/request and buzzer-side signals of the sound-effect arbiter.
interface sfx_arbiter_if;
    logic [1:0] game_state;
    logic [3:0] req;
    logic       mute;
    logic       beep;
    logic       busy;
    logic [1:0] active_id;
    logic [3:0] ack;

    modport master (
        output game_state, req, mute,
        input  beep, busy, active_id, ack
    );

    modport slave (
        input  game_state, req, mute,
        output beep, busy, active_id, ack
    );
endinterface

// File: rtl/sfx_tone_gen.sv
// Reloadable half-period square-wave divider; load restarts the tone high,
// enable lets it run, and the registered output is gated by mute.
module sfx_tone_gen #(
    parameter int HP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            enable,
    input  logic            mute,
    input  logic [HP_W-1:0] half,
    output logic            wave
);

    logic [HP_W-1:0] half_q, half_d;
    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            tone_q, tone_d;
    logic            wave_q, wave_d;

    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (load) begin
            half_d = half;
            cnt_d  = half - 1'b1;
            tone_d = 1'b1;
        end else if (enable) begin
            if (cnt_q == '0) begin
                cnt_d  = half_q - 1'b1;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            tone_d = 1'b0;
        end
        wave_d = tone_d & (load | enable) & ~mute;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= '0;
            cnt_q  <= '0;
            tone_q <= 1'b0;
            wave_q <= 1'b0;
        end else begin
            half_q <= half_d;
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/sfx_arbiter.sv
// Four-source sound-effect arbiter: latches event pulses, grants the buzzer
// by fixed priority with preemption, and sequences PLAY/GAP per effect.
module sfx_arbiter #(
    parameter int CLK_HZ = 50_000_000,
    parameter int GAP_MS = 10
) (
    input  logic          CLK_50M,
    input  logic          RST_N,
    sfx_arbiter_if.slave  bus
);
    import sfx_pkg::*;

    localparam int HP_W    = $clog2(max_half(CLK_HZ) + 1);
    localparam int DUR_W   = $clog2(max_dur(CLK_HZ) + 1);
    localparam int GAP_CYC = GAP_MS * (CLK_HZ / 1000);
    localparam int GAP_W   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    sfx_state_e       state_q, state_d;
    logic [3:0]       pending_q, pending_d;
    logic [1:0]       active_id_q, active_id_d;
    logic [3:0]       ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             game_idle, abort, grant;
    logic [3:0]       mask, eff_req, cand, clr;
    logic [1:0]       top;
    logic [HP_W-1:0]  half_ld;

    // With the game idle only the game-over event is heard, and an effect
    // other than game-over is cut short so the jingle can outlive the core.
    always_comb begin
        game_idle = (bus.game_state == GAME_IDLE);
        mask      = game_idle ? 4'b1000 : 4'b1111;
        eff_req   = bus.req & mask;
        cand      = (pending_q & mask) | eff_req;
        top       = SFX_CLICK;
        for (int i = 0; i < 4; i++)
            if (cand[i]) top = 2'(i);
        abort     = game_idle && (state_q != ST_IDLE) && (active_id_q != SFX_OVER);
        half_ld   = HP_W'(half_period(CLK_HZ, top));
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        ack_d       = '0;
        dur_d       = dur_q;
        gap_d       = gap_q;
        clr         = '0;
        grant       = 1'b0;
        unique case (state_q)
            ST_IDLE: grant = |cand;
            ST_PLAY: begin
                if (abort) begin
                    grant = |cand;
                    if (!grant) state_d = ST_IDLE;
                end else if (|cand && (top > active_id_q)) begin
                    grant = 1'b1;
                end else if (cand[active_id_q]) begin
                    // Retrigger: stretch the effect without touching tone phase.
                    ack_d[active_id_q] = 1'b1;
                    clr[active_id_q]   = 1'b1;
                    dur_d = DUR_W'(dur_cycles(CLK_HZ, active_id_q) - 1);
                end else if (dur_q == '0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_W'(GAP_CYC);
                end else begin
                    dur_d = dur_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (abort || gap_q == '0) begin
                    grant = |cand;
                    if (!grant) state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            state_d     = ST_PLAY;
            active_id_d = top;
            ack_d[top]  = 1'b1;
            clr[top]    = 1'b1;
            dur_d       = DUR_W'(dur_cycles(CLK_HZ, top) - 1);
        end

        pending_d = ((pending_q & mask) | eff_req) & ~clr;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            active_id_q <= SFX_CLICK;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            dur_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            active_id_q <= active_id_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            dur_q       <= dur_d;
            gap_q       <= gap_d;
        end
    end

    sfx_tone_gen #(.HP_W(HP_W)) u_tone (
        .clk    (CLK_50M),
        .rst_n  (RST_N),
        .load   (grant),
        .enable (state_d == ST_PLAY),
        .mute   (bus.mute),
        .half   (half_ld),
        .wave   (bus.beep)
    );

    assign bus.busy      = busy_q;
    assign bus.active_id = active_id_q;
    assign bus.ack       = ack_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Scenario bench for sfx_arbiter at CLK_HZ=100_000 (1 ms = 100 cycles);
// expected grants go into a queue and are popped as ack pulses appear.
module tb_sfx_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sfx_arbiter_if bus();

    sfx_arbiter #(.CLK_HZ(100_000), .GAP_MS(10)) dut (
        .CLK_50M (clk),
        .RST_N   (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int mon_e;

    // Every ack pulse must match the next expected grant, one-hot.
    always @(negedge clk) begin
        if (rst_n && bus.ack !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: got %b, no grant expected", bus.ack);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.ack !== 4'(1 << mon_e)) begin
                    errors++;
                    $display("FAIL ack_order: got %b, want id %0d", bus.ack, mon_e);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.mute = 1'b0;
        bus.game_state = 2'b01;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req = 4'b0000;
        bus.mute = 1'b0;
        bus.game_state = 2'b01;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.beep, bus.busy, bus.active_id, bus.ack} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got beep=%b busy=%b id=%0d ack=%b, want all 0",
                     bus.beep, bus.busy, bus.active_id, bus.ack);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_click();
        int bad, first;
        logic eb, ebusy;
        bad = 0; first = -1;
        bus.req = 4'b0001; exp_q.push_back(0);
        @(negedge clk);
        bus.req = 4'b0000;
        checks++;
        if (bus.beep !== 1'b1 || bus.busy !== 1'b1 || bus.active_id !== 2'd0) begin
            errors++;
            $display("FAIL click_grant: got beep=%b busy=%b id=%0d, want 1 1 0",
                     bus.beep, bus.busy, bus.active_id);
        end
        for (int k = 0; k <= 3001; k++) begin
            eb    = (k < 2000) ? (((k / 50) % 2) == 0) : 1'b0;
            ebusy = (k <= 3000);
            if (bus.beep !== eb || bus.busy !== ebusy) begin
                if (bad == 0) first = k;
                bad++;
            end
            if (k < 3001) @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL click_wave: %0d bad cycles, first at +%0d, want 0", bad, first);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL click_busy_drop: got busy=%b at +3001, want 0", bus.busy);
        end
        repeat (5) @(negedge clk);
    endtask

    // id1 and id2 together while muted: id2 first and silent, id1 after gap.
    task automatic test_simultaneous_mute();
        int bad, first;
        bad = 0; first = -1;
        bus.mute = 1'b1;
        @(negedge clk);
        bus.req = 4'b0110; exp_q.push_back(2); exp_q.push_back(1);
        @(negedge clk);
        bus.req = 4'b0000;
        checks++;
        if (bus.active_id !== 2'd2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_first: got id=%0d busy=%b, want 2 1", bus.active_id, bus.busy);
        end
        for (int k = 0; k <= 16000; k++) begin
            if (bus.beep !== 1'b0 || bus.busy !== 1'b1) begin
                if (bad == 0) first = k;
                bad++;
            end
            if (k == 14999) bus.mute = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mute_window: %0d bad cycles, first at +%0d, want 0", bad, first);
        end
        checks++;
        if (bus.active_id !== 2'd1 || bus.beep !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_second: got id=%0d beep=%b busy=%b at +16001, want 1 1 1",
                     bus.active_id, bus.beep, bus.busy);
        end
    endtask

    // Continues straight from the id1 grant of the previous scenario.
    task automatic test_retrigger();
        int bad, first;
        logic eb, ebusy;
        bad = 0; first = -1;
        for (int j = 0; j <= 10001; j++) begin
            eb    = (j < 9000) ? (((j / 100) % 2) == 0) : 1'b0;
            ebusy = (j <= 10000);
            if (bus.beep !== eb || bus.busy !== ebusy) begin
                if (bad == 0) first = j;
                bad++;
            end
            if (j == 2999) begin
                bus.req = 4'b0010; exp_q.push_back(1);
            end else begin
                bus.req = 4'b0000;
            end
            if (j < 10001) @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL retrigger_wave: %0d bad cycles, first at +%0d, want 0", bad, first);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_preempt();
        int bad, first, j;
        logic eb;
        bad = 0; first = -1;
        bus.req = 4'b0001; exp_q.push_back(0);
        @(negedge clk);
        bus.req = 4'b0000;
        for (int k = 0; k <= 50500; k++) begin
            j = k - 500;
            if (k < 500) eb = (((k / 50) % 2) == 0);
            else         eb = (j < 50000) ? (((j / 200) % 2) == 0) : 1'b0;
            if (bus.beep !== eb || bus.busy !== 1'b1) begin
                if (bad == 0) first = k;
                bad++;
            end
            if (k == 500) begin
                checks++;
                if (bus.active_id !== 2'd3 || bus.beep !== 1'b1) begin
                    errors++;
                    $display("FAIL preempt_grant: got id=%0d beep=%b, want 3 1",
                             bus.active_id, bus.beep);
                end
            end
            if (k == 499) begin
                bus.req = 4'b1000; exp_q.push_back(3);
            end else begin
                bus.req = 4'b0000;
            end
            if (k < 50500) @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL preempt_wave: %0d bad cycles, first at +%0d, want 0", bad, first);
        end
        apply_reset();
    endtask

    task automatic test_game_state();
        int bad;
        bad = 0;
        bus.req = 4'b0100; exp_q.push_back(2);
        @(negedge clk);
        bus.req = 4'b0000;
        for (int k = 0; k < 200; k++) begin
            bus.req = (k == 99) ? 4'b0001 : 4'b0000;
            if (k == 199) bus.game_state = 2'b00;
            @(negedge clk);
        end
        bus.req = 4'b0000;
        checks++;
        if (bus.beep !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL game_idle_stop: got beep=%b busy=%b, want 0 0", bus.beep, bus.busy);
        end
        for (int m = 0; m < 40; m++) begin
            bus.req = (m == 5) ? 4'b0001 : 4'b0000;
            if (m == 20) bus.game_state = 2'b01;
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.beep !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL game_idle_pending: %0d busy cycles after idle, want 0", bad);
        end
        bus.game_state = 2'b00;
        bus.req = 4'b1000; exp_q.push_back(3);
        @(negedge clk);
        bus.req = 4'b0000;
        checks++;
        if (bus.active_id !== 2'd3 || bus.beep !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL game_over_in_idle: got id=%0d beep=%b busy=%b, want 3 1 1",
                     bus.active_id, bus.beep, bus.busy);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int bad;
        bad = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.beep, bus.busy, bus.active_id, bus.ack} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got beep=%b busy=%b id=%0d ack=%b, want all 0",
                     bus.beep, bus.busy, bus.active_id, bus.ack);
        end
        bus.game_state = 2'b01;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 20; m++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_lost_pending: %0d busy cycles after reset, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_click();
        test_simultaneous_mute();
        test_retrigger();
        test_preempt();
        test_game_state();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_acks: %0d expected grants never seen, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
